// File: rtl/enemy_march_ctrl.sv
// rtl/enemy_march_ctrl.sv - enemy formation march sequencer
//
// Purpose: owns the enemy formation's top-left position, march direction,
// animation pose and per-enemy alive mask. Steps the formation side to side
// once every `period` frame ticks, dropping by Y_STEP at each screen edge, and
// services kill requests from the collision logic.
//
// Optional feature macro: ENEMY_SPEEDUP_EN
//   defined   -> period = max(2, FRAMES_PER_STEP - 2*dead_count)
//   undefined -> period = FRAMES_PER_STEP (no popcount logic)
//
// Ports:
//   clk         in   system clock
//   reset       in   asynchronous active-high reset
//   frame_tick  in   one-cycle pulse at start of vertical blanking
//   start       in   one-cycle pulse, (re)initialise and begin marching
//   kill_req    in   remove enemy kill_idx
//   kill_idx    in   enemy index to remove
//   kill_ack    out  one-cycle acknowledge, one cycle after kill_req
//   kill_hit    out  with kill_ack: 1 = a live enemy was removed
//   enemy_x     out  formation left edge
//   enemy_y     out  formation top edge
//   alive_mask  out  bit i = enemy i alive
//   anim_frame  out  sprite pose select
//   dir_left    out  1 = marching left
//   landed      out  formation reached Y_LIMIT (sticky until start)
//   all_dead    out  alive_mask == 0
module enemy_march_ctrl #(
  parameter int N_ENEMIES       = 8,
  parameter int SPACING         = 40,
  parameter int SPRITE_W        = 24,
  parameter int X_START         = 100,
  parameter int Y_START         = 60,
  parameter int X_MIN           = 16,
  parameter int X_MAX           = 624,
  parameter int STEP_PX         = 4,
  parameter int Y_STEP          = 12,
  parameter int Y_LIMIT         = 400,
  parameter int FRAMES_PER_STEP = 30,
  localparam int IW = (N_ENEMIES > 1) ? $clog2(N_ENEMIES) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 frame_tick,
  input  logic                 start,
  input  logic                 kill_req,
  input  logic [IW-1:0]        kill_idx,
  output logic                 kill_ack,
  output logic                 kill_hit,
  output logic [10:0]          enemy_x,
  output logic [9:0]           enemy_y,
  output logic [N_ENEMIES-1:0] alive_mask,
  output logic                 anim_frame,
  output logic                 dir_left,
  output logic                 landed,
  output logic                 all_dead
);

  localparam int FW = (N_ENEMIES - 1) * SPACING + SPRITE_W;
  localparam int CW = $clog2(FRAMES_PER_STEP + 1);

  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

  state_t          state;
  logic [CW-1:0]   frame_cnt;
  logic [CW-1:0]   period;

`ifdef ENEMY_SPEEDUP_EN
  int dead_count;
  int period_raw;

  always_comb begin
    dead_count = 0;
    for (int i = 0; i < N_ENEMIES; i++) begin
      dead_count = dead_count + int'(!alive_mask[i]);
    end
    period_raw = FRAMES_PER_STEP - 2 * dead_count;
    period     = (period_raw < 2) ? CW'(2) : CW'(period_raw);
  end
`else
  assign period = CW'(FRAMES_PER_STEP);
`endif

  logic [11:0]          x_wide;
  logic                 hit_right;
  logic                 hit_left;
  logic                 drop;
  logic [9:0]           y_drop;
  logic                 lands;
  logic                 step_now;
  logic                 kill_ok;
  logic [N_ENEMIES-1:0] mask_after;

  // Edge tests are done 12 bits wide so the left-edge test cannot underflow.
  assign x_wide    = {1'b0, enemy_x};
  assign hit_right = (x_wide + 12'(STEP_PX) + 12'(FW)) > 12'(X_MAX);
  assign hit_left  = x_wide < 12'(X_MIN + STEP_PX);
  assign drop      = dir_left ? hit_left : hit_right;
  assign y_drop    = enemy_y + 10'(Y_STEP);
  assign lands     = ({1'b0, y_drop} + 11'(SPRITE_W)) >= 11'(Y_LIMIT);

  // >= rather than == so a shrinking period never strands the counter above it.
  assign step_now  = (state == RUN) && frame_tick && !start &&
                     (frame_cnt >= period - 1'b1);

  assign kill_ok    = (state == RUN) && kill_req && !start &&
                      ({1'b0, kill_idx} < (IW+1)'(N_ENEMIES)) && alive_mask[kill_idx];
  assign mask_after = alive_mask & ~(kill_ok ? (N_ENEMIES'(1) << kill_idx) : '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      frame_cnt  <= '0;
      enemy_x    <= 11'(X_START);
      enemy_y    <= 10'(Y_START);
      alive_mask <= '1;
      anim_frame <= 1'b0;
      dir_left   <= 1'b0;
      landed     <= 1'b0;
      all_dead   <= 1'b0;
      kill_ack   <= 1'b0;
      kill_hit   <= 1'b0;
    end else begin
      kill_ack <= kill_req;
      kill_hit <= kill_ok;
      if (start) begin
        state      <= RUN;
        frame_cnt  <= '0;
        enemy_x    <= 11'(X_START);
        enemy_y    <= 10'(Y_START);
        alive_mask <= '1;
        anim_frame <= 1'b0;
        dir_left   <= 1'b0;
        landed     <= 1'b0;
        all_dead   <= 1'b0;
      end else if (state == RUN) begin
        alive_mask <= mask_after;
        all_dead   <= (mask_after == '0);
        if (step_now) begin
          frame_cnt  <= '0;
          anim_frame <= !anim_frame;
          if (drop) begin
            enemy_y  <= y_drop;
            dir_left <= !dir_left;
            if (lands) landed <= 1'b1;
          end else if (dir_left) begin
            enemy_x <= enemy_x - 11'(STEP_PX);
          end else begin
            enemy_x <= enemy_x + 11'(STEP_PX);
          end
        end else if (frame_tick) begin
          frame_cnt <= frame_cnt + 1'b1;
        end
        if ((mask_after == '0) || (step_now && drop && lands)) state <= HALT;
      end
    end
  end

endmodule

// File: tb/tb_enemy_march_ctrl.sv
// tb/tb_enemy_march_ctrl.sv - randomized self-checking bench for enemy_march_ctrl
module tb_enemy_march_ctrl;

  localparam int N   = 8;
  localparam int SP  = 40;
  localparam int SW  = 24;
  localparam int XS  = 100;
  localparam int YS  = 60;
  localparam int XMN = 16;
  localparam int XMX = 624;
  localparam int STP = 4;
  localparam int YST = 12;
  localparam int YLM = 400;
  localparam int FPS = 30;
  localparam int FWID = (N - 1) * SP + SW;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        frame_tick = 1'b0;
  logic        start = 1'b0;
  logic        kill_req = 1'b0;
  logic [2:0]  kill_idx = 3'd0;
  logic        kill_ack, kill_hit;
  logic [10:0] enemy_x;
  logic [9:0]  enemy_y;
  logic [7:0]  alive_mask;
  logic        anim_frame, dir_left, landed, all_dead;

  int errors = 0;
  int checks = 0;

  // Reference model state
  int       m_x, m_y, m_cnt;
  bit       m_dir, m_anim, m_landed, m_run, m_ack, m_hit;
  bit [7:0] m_mask;

  enemy_march_ctrl dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .start(start),
    .kill_req(kill_req), .kill_idx(kill_idx), .kill_ack(kill_ack), .kill_hit(kill_hit),
    .enemy_x(enemy_x), .enemy_y(enemy_y), .alive_mask(alive_mask),
    .anim_frame(anim_frame), .dir_left(dir_left), .landed(landed), .all_dead(all_dead)
  );

  always #5 clk = ~clk;

  task automatic model_init(input bit run);
    m_x = XS; m_y = YS; m_cnt = 0; m_dir = 0; m_anim = 0;
    m_landed = 0; m_mask = 8'hFF; m_run = run;
  endtask

  // Drive one cycle of inputs and advance the model by the same rules.
  task automatic do_cycle(input bit tick, input bit st, input bit kr, input int ki);
    int dead, period;
    frame_tick = tick; start = st; kill_req = kr; kill_idx = 3'(ki);
    m_ack = kr;
    m_hit = 0;
    if (st) begin
      model_init(1);
    end else if (m_run) begin
      dead = N - $countones(m_mask);
`ifdef ENEMY_SPEEDUP_EN
      period = (FPS - 2 * dead < 2) ? 2 : FPS - 2 * dead;
`else
      period = FPS;
      if (dead < 0) period = 0;
`endif
      m_hit = kr && (ki < N) && m_mask[ki];
      if (tick) begin
        m_cnt++;
        if (m_cnt >= period) begin
          bit at_edge;
          m_cnt = 0;
          m_anim = !m_anim;
          at_edge = m_dir ? (m_x < XMN + STP) : (m_x + STP + FWID > XMX);
          if (at_edge) begin
            m_y = m_y + YST;
            m_dir = !m_dir;
            if (m_y + SW >= YLM) begin
              m_landed = 1;
              m_run = 0;
            end
          end else begin
            m_x = m_dir ? m_x - STP : m_x + STP;
          end
        end
      end
      if (m_hit) m_mask[ki] = 1'b0;
      if (m_mask == 8'h00) m_run = 0;
    end
    @(posedge clk);
    #1;
    frame_tick = 0; start = 0; kill_req = 0;
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (enemy_x !== 11'd100 || enemy_y !== 10'd60 || alive_mask !== 8'hFF || anim_frame !== 1'b0 ||
        dir_left !== 1'b0 || landed !== 1'b0 || all_dead !== 1'b0 || kill_ack !== 1'b0 || kill_hit !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: got x=%0d y=%0d mask=%h anim=%b dir=%b landed=%b dead=%b ack=%b hit=%b, want 100/60/ff/0/0/0/0/0/0",
               enemy_x, enemy_y, alive_mask, anim_frame, dir_left, landed, all_dead, kill_ack, kill_hit);
    end
    reset = 0;
    model_init(0);
    m_ack = 0; m_hit = 0;
    for (int i = 0; i < 40; i++) do_cycle(1, 0, 0, 0);
    checks++;
    if (enemy_x !== 11'd100 || anim_frame !== 1'b0) begin
      errors++;
      $display("FAIL idle_ignores_tick: got x=%0d anim=%b, want x=100 anim=0", enemy_x, anim_frame);
    end
  endtask

  task automatic test_first_step;
    do_cycle(0, 1, 0, 0);
    for (int i = 0; i < 29; i++) begin
      do_cycle(1, 0, 0, 0);
      do_cycle(0, 0, 0, 0);
    end
    checks++;
    if (enemy_x !== 11'd100 || anim_frame !== 1'b0) begin
      errors++;
      $display("FAIL before_first_step: got x=%0d anim=%b, want x=100 anim=0", enemy_x, anim_frame);
    end
    do_cycle(1, 0, 0, 0);
    checks++;
    if (enemy_x !== 11'd104 || anim_frame !== 1'b1 || enemy_y !== 10'd60) begin
      errors++;
      $display("FAIL first_step: got x=%0d anim=%b y=%0d, want x=104 anim=1 y=60", enemy_x, anim_frame, enemy_y);
    end
  endtask

  task automatic test_edge_drop;
    int n;
    int prev_x;
    n = 0;
    while (dir_left !== 1'b1 && n < 3000) begin
      do_cycle(1, 0, 0, 0);
      n++;
    end
    checks++;
    if (dir_left !== 1'b1 || enemy_x !== 11'd320 || enemy_y !== 10'd72) begin
      errors++;
      $display("FAIL edge_drop: got dir=%b x=%0d y=%0d, want dir=1 x=320 y=72", dir_left, enemy_x, enemy_y);
    end
    checks++;
    if (anim_frame !== m_anim) begin
      errors++;
      $display("FAIL edge_anim: got %b, want %b", anim_frame, m_anim);
    end
    prev_x = int'(enemy_x);
    n = 0;
    while (int'(enemy_x) == prev_x && n < 40) begin
      do_cycle(1, 0, 0, 0);
      n++;
    end
    checks++;
    if (enemy_x !== 11'd316 || enemy_y !== 10'd72) begin
      errors++;
      $display("FAIL step_left: got x=%0d y=%0d, want x=316 y=72", enemy_x, enemy_y);
    end
  endtask

  task automatic test_kill;
    do_cycle(0, 0, 1, 3);
    checks++;
    if (kill_ack !== 1'b1 || kill_hit !== 1'b1 || alive_mask !== 8'hF7) begin
      errors++;
      $display("FAIL kill_3: got ack=%b hit=%b mask=%h, want 1/1/f7", kill_ack, kill_hit, alive_mask);
    end
    do_cycle(0, 0, 0, 0);
    checks++;
    if (kill_ack !== 1'b0) begin
      errors++;
      $display("FAIL ack_single_pulse: got ack=%b, want 0", kill_ack);
    end
    do_cycle(0, 0, 1, 3);
    checks++;
    if (kill_ack !== 1'b1 || kill_hit !== 1'b0 || alive_mask !== 8'hF7) begin
      errors++;
      $display("FAIL kill_3_again: got ack=%b hit=%b mask=%h, want 1/0/f7", kill_ack, kill_hit, alive_mask);
    end
    do_cycle(0, 0, 1, 0);
    checks++;
    if (kill_ack !== 1'b1 || kill_hit !== 1'b1) begin
      errors++;
      $display("FAIL b2b_first: got ack=%b hit=%b, want 1/1", kill_ack, kill_hit);
    end
    do_cycle(0, 0, 1, 1);
    checks++;
    if (kill_ack !== 1'b1 || kill_hit !== 1'b1 || alive_mask !== 8'hF4) begin
      errors++;
      $display("FAIL b2b_second: got ack=%b hit=%b mask=%h, want 1/1/f4", kill_ack, kill_hit, alive_mask);
    end
  endtask

  task automatic test_kill_all;
    int held_x;
    for (int i = 2; i < 8; i++) begin
      if (i != 3) do_cycle(0, 0, 1, i);
    end
    checks++;
    if (all_dead !== 1'b1 || alive_mask !== 8'h00 || kill_hit !== 1'b1) begin
      errors++;
      $display("FAIL kill_all: got dead=%b mask=%h hit=%b, want 1/00/1", all_dead, alive_mask, kill_hit);
    end
    held_x = int'(enemy_x);
    for (int i = 0; i < 70; i++) do_cycle(1, 0, 0, 0);
    checks++;
    if (int'(enemy_x) != held_x || enemy_x !== 11'(m_x)) begin
      errors++;
      $display("FAIL halt_no_move: got x=%0d, want %0d", enemy_x, held_x);
    end
    do_cycle(1, 1, 1, 2);
    checks++;
    if (enemy_x !== 11'd100 || enemy_y !== 10'd60 || alive_mask !== 8'hFF || all_dead !== 1'b0 ||
        anim_frame !== 1'b0 || dir_left !== 1'b0 || kill_ack !== 1'b1 || kill_hit !== 1'b0) begin
      errors++;
      $display("FAIL restart: got x=%0d y=%0d mask=%h dead=%b anim=%b dir=%b ack=%b hit=%b, want 100/60/ff/0/0/0/1/0",
               enemy_x, enemy_y, alive_mask, all_dead, anim_frame, dir_left, kill_ack, kill_hit);
    end
  endtask

  task automatic test_random;
    bit t, s, k;
    int ki;
    for (int c = 0; c < 3000; c++) begin
      t  = ($urandom_range(0, 3) != 0);
      s  = ($urandom_range(0, 299) == 0);
      k  = ($urandom_range(0, 19) == 0);
      ki = $urandom_range(0, 7);
      do_cycle(t, s, k, ki);
      checks++;
      if (enemy_x !== 11'(m_x) || enemy_y !== 10'(m_y) || alive_mask !== m_mask || anim_frame !== m_anim ||
          dir_left !== m_dir || landed !== m_landed || all_dead !== (m_mask == 8'h00) ||
          kill_ack !== m_ack || kill_hit !== m_hit) begin
        errors++;
        $display("FAIL random_c%0d: got x=%0d y=%0d mask=%h anim=%b dir=%b land=%b dead=%b ack=%b hit=%b, want x=%0d y=%0d mask=%h anim=%b dir=%b land=%b ack=%b hit=%b",
                 c, enemy_x, enemy_y, alive_mask, anim_frame, dir_left, landed, all_dead, kill_ack, kill_hit,
                 m_x, m_y, m_mask, m_anim, m_dir, m_landed, m_ack, m_hit);
      end
    end
  endtask

  task automatic test_landing;
    int n;
    int held_x;
    bit held_anim;
    do_cycle(0, 1, 0, 0);
    n = 0;
    while (landed !== 1'b1 && n < 70000) begin
      do_cycle(1, 0, 0, 0);
      n++;
    end
    checks++;
    if (landed !== 1'b1 || enemy_y !== 10'd384) begin
      errors++;
      $display("FAIL landing: got landed=%b y=%0d after %0d ticks, want landed=1 y=384", landed, enemy_y, n);
    end
    checks++;
    if (landed !== m_landed || enemy_x !== 11'(m_x) || dir_left !== m_dir || anim_frame !== m_anim) begin
      errors++;
      $display("FAIL landing_model: got land=%b x=%0d dir=%b anim=%b, want %b/%0d/%b/%b",
               landed, enemy_x, dir_left, anim_frame, m_landed, m_x, m_dir, m_anim);
    end
    held_x = int'(enemy_x);
    held_anim = anim_frame;
    for (int i = 0; i < 70; i++) do_cycle(1, 0, 0, 0);
    checks++;
    if (int'(enemy_x) != held_x || anim_frame !== held_anim || landed !== 1'b1) begin
      errors++;
      $display("FAIL landed_halt: got x=%0d anim=%b landed=%b, want x=%0d anim=%b landed=1",
               enemy_x, anim_frame, landed, held_x, held_anim);
    end
  endtask

  task automatic test_reset_mid_march;
    do_cycle(0, 1, 0, 0);
    for (int i = 0; i < 100; i++) do_cycle(1, 0, (i == 50), 6);
    kill_req = 1;
    kill_idx = 3'd2;
    @(posedge clk);
    #3;
    reset = 1;
    #1;
    kill_req = 0;
    checks++;
    if (enemy_x !== 11'd100 || enemy_y !== 10'd60 || alive_mask !== 8'hFF || anim_frame !== 1'b0 ||
        dir_left !== 1'b0 || landed !== 1'b0 || all_dead !== 1'b0 || kill_ack !== 1'b0 || kill_hit !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got x=%0d y=%0d mask=%h anim=%b dir=%b landed=%b dead=%b ack=%b hit=%b, want 100/60/ff/0/0/0/0/0/0",
               enemy_x, enemy_y, alive_mask, anim_frame, dir_left, landed, all_dead, kill_ack, kill_hit);
    end
    @(posedge clk);
    #1;
    reset = 0;
    model_init(0);
  endtask

  initial begin
    test_reset();
    test_first_step();
    test_edge_drop();
    test_kill();
    test_kill_all();
    test_random();
    test_landing();
    test_reset_mid_march();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
